// File: rtl/dma_desc_dispatch.sv
// Multi-channel DMA descriptor dispatcher: per-channel FWFT FIFOs, in-flight caps and sticky errors.
// Optional per-channel dispatch counters are built when DMA_DISPATCH_PERF_CNT_EN is defined.
module dma_desc_dispatch #(
    parameter  int NUM_CHANNELS = 2,
    parameter  int FIFO_DEPTH   = 16,
    parameter  int MAX_INFLIGHT = 32,
    parameter  int ADDR_WIDTH   = 64,
    parameter  int LEN_WIDTH    = 32,
    localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int DESC_W       = 2 * ADDR_WIDTH + LEN_WIDTH,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1,
    localparam int IF_W         = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DESC_W-1:0]              in_desc,
    input  logic [CH_W-1:0]                in_ch,
    output logic [NUM_CHANNELS-1:0]        ch_valid,
    input  logic [NUM_CHANNELS-1:0]        ch_ready,
    output logic [NUM_CHANNELS*DESC_W-1:0] ch_desc,
    input  logic [NUM_CHANNELS-1:0]        ch_done,
    output logic [NUM_CHANNELS*CNT_W-1:0]  fifo_cnt,
    output logic [NUM_CHANNELS*IF_W-1:0]   inflight_cnt,
    output logic [2:0]                     err,
    input  logic                           err_clear,
    output logic [NUM_CHANNELS*32-1:0]     disp_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic                    bad_ch;
    logic                    zero_len;
    logic                    sel_full;
    logic                    accept;
    logic                    drop_bad;
    logic                    drop_zero;
    logic                    enq;
    logic [NUM_CHANNELS-1:0] full;
    logic [NUM_CHANNELS-1:0] uflow;

    // NOTE: always_comb uses blocking assignments with a default first, so no latch is inferred.
    always_comb begin
        bad_ch   = (32'(in_ch) >= 32'(NUM_CHANNELS));
        zero_len = (in_desc[LEN_WIDTH-1:0] == '0);
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (in_ch == CH_W'(i)) sel_full = full[i];
        end
        // Descriptors that are going to be dropped are always taken so the source never stalls on them.
        in_ready = reset_n && (bad_ch || zero_len || !sel_full);
    end

    assign accept    = in_valid && in_ready;
    assign drop_bad  = accept && bad_ch;
    assign drop_zero = accept && !bad_ch && zero_len;
    assign enq       = accept && !bad_ch && !zero_len;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [DESC_W-1:0] mem [FIFO_DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [IF_W-1:0]   inflight;
        logic              push;
        logic              pop;
        logic              valid;

        assign full[i]  = (count == CNT_W'(FIFO_DEPTH));
        assign push     = enq && (in_ch == CH_W'(i));
        assign valid    = (count != '0) && (inflight < IF_W'(MAX_INFLIGHT));
        assign pop      = valid && ch_ready[i];
        assign uflow[i] = ch_done[i] && !pop && (inflight == '0);

        // NOTE: the storage array has no reset; only pointers and counts decide what is valid.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_desc;
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                inflight <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                // A completion against an empty in-flight count is an error, not a decrement.
                if (pop && !ch_done[i])
                    inflight <= inflight + IF_W'(1);
                else if (!pop && ch_done[i] && inflight != '0)
                    inflight <= inflight - IF_W'(1);
            end
        end

        assign ch_valid[i]                   = valid;
        assign ch_desc[i*DESC_W +: DESC_W]   = mem[rd_ptr];
        assign fifo_cnt[i*CNT_W +: CNT_W]    = count;
        assign inflight_cnt[i*IF_W +: IF_W]  = inflight;

`ifdef DMA_DISPATCH_PERF_CNT_EN
        logic [31:0] disp;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  disp <= '0;
            else if (pop)  disp <= disp + 32'd1;
        end
        assign disp_cnt[i*32 +: 32] = disp;
`else
        assign disp_cnt[i*32 +: 32] = '0;
`endif
    end

    // Sticky error flags: a new event in the clear cycle survives the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err <= '0;
        else
            err <= (err_clear ? 3'b000 : err) | {|uflow, drop_zero, drop_bad};
    end

endmodule

// File: tb/tb_dma_desc_dispatch.sv
// Scoreboard bench for dma_desc_dispatch: directed pushes queue expected heads, a monitor checks pops.
module tb_dma_desc_dispatch;

    localparam int NC  = 3;
    localparam int FD  = 16;
    localparam int MI  = 4;
    localparam int AW  = 16;
    localparam int LW  = 8;
    localparam int DW  = 2 * AW + LW;
    localparam int CW  = 2;
    localparam int FCW = 5;
    localparam int ICW = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_desc;
    logic [CW-1:0]     in_ch;
    logic [NC-1:0]     ch_valid;
    logic [NC-1:0]     ch_ready;
    logic [NC*DW-1:0]  ch_desc;
    logic [NC-1:0]     ch_done;
    logic [NC*FCW-1:0] fifo_cnt;
    logic [NC*ICW-1:0] inflight_cnt;
    logic [2:0]        err;
    logic              err_clear;
    logic [NC*32-1:0]  disp_cnt;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [NC][$];

    dma_desc_dispatch #(
        .NUM_CHANNELS(NC), .FIFO_DEPTH(FD), .MAX_INFLIGHT(MI),
        .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_desc(in_desc), .in_ch(in_ch), .ch_valid(ch_valid), .ch_ready(ch_ready),
        .ch_desc(ch_desc), .ch_done(ch_done), .fifo_cnt(fifo_cnt),
        .inflight_cnt(inflight_cnt), .err(err), .err_clear(err_clear), .disp_cnt(disp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FCW-1:0] fc(input int i);
        return fifo_cnt[i*FCW +: FCW];
    endfunction

    function automatic logic [ICW-1:0] ic(input int i);
        return inflight_cnt[i*ICW +: ICW];
    endfunction

    function automatic logic [31:0] dc(input int i);
        return disp_cnt[i*32 +: 32];
    endfunction

    function automatic logic [DW-1:0] mk(input int n, input int ch, input int len);
        return {16'(16'h1000 + n), 16'(16'h2000 + 16 * ch + n), 8'(len)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Present one descriptor that must be taken this cycle; enq says whether it lands in a FIFO.
    task automatic send(input int ch, input logic [DW-1:0] d, input logic enq);
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        in_desc  = d;
        #1;
        check("in_ready", 64'(in_ready), 64'd1);
        if (enq) exp_q[ch].push_back(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic done_pulse(input logic [NC-1:0] m);
        ch_done = m;
        tick();
        ch_done = '0;
    endtask

    // Monitor: every handshake must match the oldest expected descriptor of that channel.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < NC; i++) begin
                if (ch_valid[i] && ch_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_unexpected ch%0d: got %0h expected none", i, ch_desc[i*DW +: DW]);
                    end else begin
                        check($sformatf("pop_desc ch%0d", i), 64'(ch_desc[i*DW +: DW]), 64'(exp_q[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_desc   = '0;
        in_ch     = '0;
        ch_ready  = '0;
        ch_done   = '0;
        err_clear = 1'b0;
        #3;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst ch_valid", 64'(ch_valid), 64'd0);
        check("rst fifo_cnt", 64'(fifo_cnt), 64'd0);
        check("rst inflight", 64'(inflight_cnt), 64'd0);
        check("rst err", 64'(err), 64'd0);
        check("rst disp_cnt", 64'(disp_cnt), 64'd0);
        cycles(2);
        reset_n = 1'b1;
        tick();

        // Ordered dispatch: 3 on ch0, 2 on ch1.
        for (int n = 0; n < 3; n++) send(0, mk(n, 0, n + 1), 1'b1);
        for (int n = 0; n < 2; n++) send(1, mk(n, 1, n + 5), 1'b1);
        check("t1 ch_valid", 64'(ch_valid), 64'b011);
        check("t1 fifo0", 64'(fc(0)), 64'd3);
        check("t1 fifo1", 64'(fc(1)), 64'd2);
        ch_ready = 3'b011;
        cycles(6);
        ch_ready = '0;
        check("t1 fifo0 drained", 64'(fc(0)), 64'd0);
        check("t1 fifo1 drained", 64'(fc(1)), 64'd0);
        check("t1 inflight0", 64'(ic(0)), 64'd3);
        check("t1 inflight1", 64'(ic(1)), 64'd2);
        done_pulse(3'b011);
        done_pulse(3'b011);
        done_pulse(3'b001);
        check("t1 inflight back", 64'(inflight_cnt), 64'd0);

        // Full FIFO on ch0; 17th blocked even with a same-cycle pop.
        for (int n = 0; n < FD; n++) send(0, mk(n + 8, 0, n + 1), 1'b1);
        check("t2 fifo0 full", 64'(fc(0)), 64'd16);
        in_valid = 1'b1;
        in_ch    = 2'd0;
        in_desc  = mk(40, 0, 9);
        #1;
        check("t2 in_ready full", 64'(in_ready), 64'd0);
        ch_ready = 3'b001;
        #1;
        check("t2 in_ready full+pop", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        ch_ready = '0;
        check("t2 fifo0 after pop", 64'(fc(0)), 64'd15);
        check("t2 in_ready room", 64'(in_ready), 64'd1);
        exp_q[0].push_back(in_desc);
        tick();
        in_valid = 1'b0;
        check("t2 fifo0 refilled", 64'(fc(0)), 64'd16);
        send(1, mk(50, 1, 3), 1'b1);
        check("t2 fifo1", 64'(fc(1)), 64'd1);
        ch_ready = 3'b001;
        ch_done  = 3'b001;
        cycles(16);
        ch_ready = '0;
        check("t2 inflight0 pop+done", 64'(ic(0)), 64'd1);
        check("t2 fifo0 empty", 64'(fc(0)), 64'd0);
        ch_done = '0;
        done_pulse(3'b001);
        ch_ready = 3'b010;
        tick();
        ch_ready = '0;
        done_pulse(3'b010);
        check("t2 inflight clear", 64'(inflight_cnt), 64'd0);
        check("t2 err clean", 64'(err), 64'd0);

        // In-flight cap on ch1.
        for (int n = 0; n < 6; n++) send(1, mk(n + 60, 1, n + 2), 1'b1);
        ch_ready = 3'b010;
        cycles(6);
        check("t3 inflight1 cap", 64'(ic(1)), 64'd4);
        check("t3 fifo1 left", 64'(fc(1)), 64'd2);
        check("t3 ch_valid1 low", 64'(ch_valid[1]), 64'd0);
        ch_done = 3'b010;
        tick();
        ch_done = '0;
        check("t3 ch_valid1 back", 64'(ch_valid[1]), 64'd1);
        tick();
        check("t3 inflight1 refill", 64'(ic(1)), 64'd4);
        check("t3 fifo1 one", 64'(fc(1)), 64'd1);
        check("t3 ch_valid1 low again", 64'(ch_valid[1]), 64'd0);
        ch_done = 3'b010;
        cycles(5);
        ch_done  = '0;
        ch_ready = '0;
        check("t3 inflight1 zero", 64'(ic(1)), 64'd0);
        check("t3 fifo1 zero", 64'(fc(1)), 64'd0);
        check("t3 err clean", 64'(err), 64'd0);

        // Drops and sticky errors.
        send(3, mk(70, 3, 4), 1'b0);
        send(0, mk(71, 0, 0), 1'b0);
        check("t4 err bad+zero", 64'(err), 64'b011);
        check("t4 nothing queued", 64'(fifo_cnt), 64'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4 err cleared", 64'(err), 64'd0);
        send(3, mk(72, 3, 0), 1'b0);
        check("t4 bad_ch precedence", 64'(err), 64'b001);
        err_clear = 1'b1;
        send(3, mk(73, 3, 5), 1'b0);
        err_clear = 1'b0;
        check("t4 set wins clear", 64'(err), 64'b001);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        done_pulse(3'b100);
        check("t4 underflow", 64'(err), 64'b100);
        check("t4 inflight2 stays 0", 64'(ic(2)), 64'd0);

        // Same-cycle pop and completion at inflight 2.
        for (int n = 0; n < 3; n++) send(2, mk(n + 80, 2, n + 7), 1'b1);
        ch_ready = 3'b100;
        cycles(2);
        check("t5 inflight2 two", 64'(ic(2)), 64'd2);
        ch_done = 3'b100;
        tick();
        ch_done  = '0;
        ch_ready = '0;
        check("t5 inflight2 held", 64'(ic(2)), 64'd2);
        check("t5 fifo2 empty", 64'(fc(2)), 64'd0);

        // Asynchronous reset with descriptors queued.
        for (int n = 0; n < 5; n++) send(0, mk(n + 90, 0, n + 1), 1'b1);
        check("t6 fifo0 five", 64'(fc(0)), 64'd5);
        reset_n = 1'b0;
        for (int i = 0; i < NC; i++) exp_q[i].delete();
        #1;
        check("t6 rst ch_valid", 64'(ch_valid), 64'd0);
        check("t6 rst fifo_cnt", 64'(fifo_cnt), 64'd0);
        check("t6 rst inflight", 64'(inflight_cnt), 64'd0);
        check("t6 rst err", 64'(err), 64'd0);
        check("t6 rst in_ready", 64'(in_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        done_pulse(3'b100);
        check("t6 late done underflow", 64'(err), 64'b100);

        // Dispatch counters: 10 pops on ch0 since the last reset.
        for (int n = 0; n < 10; n++) send(0, mk(n + 100, 0, n + 1), 1'b1);
        ch_ready = 3'b001;
        ch_done  = 3'b001;
        cycles(10);
        ch_ready = '0;
        ch_done  = '0;
        check("t7 fifo0 drained", 64'(fc(0)), 64'd0);
        check("t7 inflight0 zero", 64'(ic(0)), 64'd0);
`ifdef DMA_DISPATCH_PERF_CNT_EN
        check("t7 disp0", 64'(dc(0)), 64'd10);
`else
        check("t7 disp0", 64'(dc(0)), 64'd0);
`endif
        check("t7 disp1", 64'(dc(1)), 64'd0);

        for (int i = 0; i < NC; i++)
            check($sformatf("leftover ch%0d", i), 64'(exp_q[i].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_desc_dispatch.md
# dma_desc_dispatch

Multi-channel descriptor dispatcher between the CSR manager and a bank of DMA copy engines. Accepts copy descriptors on one valid/ready input, steers each into a per-channel FIFO selected by its channel field, and presents each channel's head descriptor to its engine. Enforces a per-channel cap on outstanding copies using engine completion pulses, and reports occupancy, in-flight counts and sticky errors for CSR readback.

## Interface
- NUM_CHANNELS, 2: number of engine channels (1..8); CH_W = max(1, $clog2(NUM_CHANNELS))
- FIFO_DEPTH, 16: entries per channel FIFO, power of two, ≥2
- MAX_INFLIGHT, 32: outstanding descriptors allowed per channel
- ADDR_WIDTH, 64: source/destination address width
- LEN_WIDTH, 32: byte-length width; DESC_W = 2*ADDR_WIDTH + LEN_WIDTH, packed {src, dst, len} MSB→LSB

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous assert, active-low reset
- in_valid  in  1  input descriptor valid
- in_ready  out  1  input accepted when in_valid && in_ready
- in_desc  in  DESC_W  descriptor
- in_ch  in  CH_W  target channel
- ch_valid  out  NUM_CHANNELS  per-channel head descriptor valid
- ch_ready  in  NUM_CHANNELS  engine takes head descriptor
- ch_desc  out  NUM_CHANNELS*DESC_W  head descriptors, channel i at [i*DESC_W +: DESC_W]
- ch_done  in  NUM_CHANNELS  one-cycle completion pulse per finished descriptor
- fifo_cnt  out  NUM_CHANNELS*($clog2(FIFO_DEPTH)+1)  per-channel occupancy
- inflight_cnt  out  NUM_CHANNELS*($clog2(MAX_INFLIGHT)+1)  per-channel outstanding count
- err  out  3  sticky {done_underflow, zero_len, bad_ch}
- err_clear  in  1  one-cycle clear of err
- disp_cnt  out  NUM_CHANNELS*32  per-channel dispatched counts (see Configuration)

## Operation
- Enqueue: in_ready = !full[in_ch] when in_ch < NUM_CHANNELS; in_ready depends combinationally on in_ch; source holds in_desc/in_ch stable while in_valid.
- Descriptor with in_ch ≥ NUM_CHANNELS: in_ready=1, dropped, err[0] set.
- Descriptor with len == 0: in_ready=1, dropped, err[1] set (bad_ch takes precedence, only err[0] set).
- FIFO: first-word-fall-through; ch_desc[i] is head entry, don't-care when ch_valid[i]=0.
- Dispatch: ch_valid[i] = !empty[i] && inflight[i] < MAX_INFLIGHT. Handshake ch_valid[i] && ch_ready[i] pops head and increments inflight[i].
- Completion: ch_done[i] decrements inflight[i]. Pop and done same cycle: inflight unchanged. Done with inflight==0 and no pop: ignored, err[2] set.
- Channels fully independent; no arbitration between them.
- err bits sticky; err_clear clears all; set and clear same cycle: set wins.

## Timing
- Reset values: in_ready=0 while reset_n=0, then follows full; ch_valid=0, fifo_cnt=0, inflight_cnt=0, err=0, disp_cnt=0. All FIFO contents discarded.
- Accept at edge N → ch_valid rises after edge N (visible cycle N+1); fifo_cnt increments same edge.
- Full: enqueue blocked even if same-cycle pop; fifo_cnt max = FIFO_DEPTH.
- Simultaneous push and pop on non-empty, non-full FIFO: count unchanged, order preserved.
- Pointers wrap modulo FIFO_DEPTH.
- ch_valid[i] drops the cycle after inflight reaches MAX_INFLIGHT; reasserts the cycle after a ch_done reduces it.
- Reset mid-operation: all state cleared asynchronously; outstanding engine completions after reset are counted as underflow.

## Configuration
- DMA_DISPATCH_PERF_CNT_EN defined: disp_cnt[i] increments on each channel-i pop, wraps at 2^32, cleared only by reset.
- Not defined: counters not built; disp_cnt tied to 0.

## Test plan
- NUM_CHANNELS=2: push 3 descriptors to ch0, 2 to ch1, ch_ready=1 → ch0 emits them in order, fifo_cnt returns 0, inflight_cnt = {2,3}.
- FIFO_DEPTH=16, ch_ready[0]=0: push 17 to ch0 → 16 accepted, in_ready low on 17th, fifo_cnt[0]=16; ch1 pushes still accepted.
- MAX_INFLIGHT=4: 6 queued on ch1 → 4 dispatched, ch_valid[1]=0; one ch_done[1] → 5th dispatched next cycle.
- in_ch=3 then len=0 → both accepted and dropped, err=3'b011; err_clear → err=0; ch_done with inflight 0 → err=3'b100.
- Same-cycle pop and ch_done at inflight=2 → inflight stays 2; reset_n low with 5 queued → all counts 0, ch_valid 0 immediately.
- With DMA_DISPATCH_PERF_CNT_EN: 10 pops on ch0 → disp_cnt[0]=10; preload 32'hFFFF_FFFF equivalent via 2^32 pops in fast model → wraps to 0; without macro → disp_cnt=0.
